// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants shared by the sync
// generator and the text renderer.
package vga_timing_pkg;

  localparam int COORD_W = 10;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL =
    VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL =
    VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int VGA_H_SYNC_START = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC - 1;
  localparam int VGA_V_SYNC_START = VGA_V_DISPLAY + VGA_V_FRONT;
  localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC - 1;

  typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
// Mod-DIV divider producing a one-clk pixel strobe.
// p_tick is high exactly while the divider sits at DIV-1.
module pixel_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] tick_cnt;
  logic [W-1:0] tick_nxt;

  assign tick_nxt = (tick_cnt == LAST) ? '0 : tick_cnt + W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      p_tick   <= 1'b0;
    end else begin
      tick_cnt <= tick_nxt;
      p_tick   <= (tick_nxt == LAST);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: h/v counters, sync decode and
// per-pixel / per-frame strobes.
import vga_timing_pkg::*;

module vga_sync_gen #(
  parameter int   DIV         = 4,
  parameter int   H_DISPLAY   = VGA_H_DISPLAY,
  parameter int   H_FRONT     = VGA_H_FRONT,
  parameter int   H_SYNC      = VGA_H_SYNC,
  parameter int   H_BACK      = VGA_H_BACK,
  parameter int   V_DISPLAY   = VGA_V_DISPLAY,
  parameter int   V_FRONT     = VGA_V_FRONT,
  parameter int   V_SYNC      = VGA_V_SYNC,
  parameter int   V_BACK      = VGA_V_BACK,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               p_tick,
  output logic               frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS  = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS  = coord_t'(V_DISPLAY);
  localparam coord_t H_SS   = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t H_SE   = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t V_SS   = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t V_SE   = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  coord_t h_cnt;
  coord_t v_cnt;
  coord_t h_nxt;
  coord_t v_nxt;
  logic   tick;
  logic   h_in_sync;
  logic   v_in_sync;

  pixel_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .p_tick (tick)
  );

  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (tick) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
      end else begin
        h_nxt = h_cnt + coord_t'(1);
      end
    end
  end

  // Syncs decode the next-state counts so they line up with pixel_x/y.
  assign h_in_sync = (h_nxt >= H_SS) && (h_nxt <= H_SE);
  assign v_in_sync = (v_nxt >= V_SS) && (v_nxt <= V_SE);

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= ~SYNC_ACTIVE;
      vsync       <= ~SYNC_ACTIVE;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      hsync       <= h_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync       <= v_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      frame_start <= tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);
    end
  end

  assign pixel_x  = h_cnt;
  assign pixel_y  = v_cnt;
  assign video_on = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign p_tick   = tick;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size timing on one line, reduced
// geometries for vertical, frame and DIV=1 behaviour.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  logic [9:0] xa, ya, xb, yb, xc, yc;
  logic von_a, hs_a, vs_a, pt_a, fs_a;
  logic von_b, hs_b, vs_b, pt_b, fs_b;
  logic von_c, hs_c, vs_c, pt_c, fs_c;

  int errors = 0;
  int checks = 0;

  // Full 640x480 timing, DIV=4, active-low syncs.
  vga_sync_gen dut_a (
    .clk         (clk),
    .reset       (rst_a),
    .pixel_x     (xa),
    .pixel_y     (ya),
    .video_on    (von_a),
    .hsync       (hs_a),
    .vsync       (vs_a),
    .p_tick      (pt_a),
    .frame_start (fs_a)
  );

  // 17x15 raster: hsync 12..14, vsync 10..11, frame 1020 clks.
  vga_sync_gen #(
    .DIV(4), .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_ACTIVE(1'b0)
  ) dut_b (
    .clk         (clk),
    .reset       (rst_b),
    .pixel_x     (xb),
    .pixel_y     (yb),
    .video_on    (von_b),
    .hsync       (hs_b),
    .vsync       (vs_b),
    .p_tick      (pt_b),
    .frame_start (fs_b)
  );

  // Same raster, DIV=1, active-high syncs: frame 255 clks.
  vga_sync_gen #(
    .DIV(1), .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_ACTIVE(1'b1)
  ) dut_c (
    .clk         (clk),
    .reset       (rst_c),
    .pixel_x     (xc),
    .pixel_y     (yc),
    .video_on    (von_c),
    .hsync       (hs_c),
    .vsync       (vs_c),
    .p_tick      (pt_c),
    .frame_start (fs_c)
  );

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    rst_a = 1'b1;
    repeat (3) cyc();
    checks += 7;
    if (xa !== 10'd0) begin errors++; $display("FAIL rst_x got %0d want 0", xa); end
    if (ya !== 10'd0) begin errors++; $display("FAIL rst_y got %0d want 0", ya); end
    if (hs_a !== 1'b1) begin errors++; $display("FAIL rst_hs got %b want 1", hs_a); end
    if (vs_a !== 1'b1) begin errors++; $display("FAIL rst_vs got %b want 1", vs_a); end
    if (von_a !== 1'b1) begin errors++; $display("FAIL rst_von got %b want 1", von_a); end
    if (pt_a !== 1'b0) begin errors++; $display("FAIL rst_pt got %b want 0", pt_a); end
    if (fs_a !== 1'b0) begin errors++; $display("FAIL rst_fs got %b want 0", fs_a); end
    rst_a = 1'b0;
    cyc();
    checks++;
    if (pt_a !== 1'b0) begin errors++; $display("FAIL pt_clk1 got %b want 0", pt_a); end
    cyc();
    checks++;
    if (pt_a !== 1'b0) begin errors++; $display("FAIL pt_clk2 got %b want 0", pt_a); end
    cyc();
    checks += 2;
    if (pt_a !== 1'b1) begin errors++; $display("FAIL pt_clk3 got %b want 1", pt_a); end
    if (xa !== 10'd0) begin errors++; $display("FAIL pt_x0 got %0d want 0", xa); end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin cyc(); n++; end while (pt_a !== 1'b1 && n < 10);
      checks++;
      if (n != 4) begin errors++; $display("FAIL pt_period got %0d want 4", n); end
    end
  endtask

  task automatic test_line();
    int px, fall_x, rise_x, vf_x, vf_prev, low_cnt, step_err;
    int wrap_prev, wrap_y, wrap_hs, wrap_von;
    logic phs, pvon, wrapped;
    px = xa; phs = hs_a; pvon = von_a;
    fall_x = -1; rise_x = -1; vf_x = -1; vf_prev = -1;
    low_cnt = 0; step_err = 0; wrapped = 1'b0;
    wrap_prev = -1; wrap_y = -1; wrap_hs = -1; wrap_von = -1;
    for (int i = 0; i < 3400 && !wrapped; i++) begin
      cyc();
      if (hs_a === 1'b0) low_cnt++;
      if (phs && !hs_a) fall_x = xa;
      if (!phs && hs_a) rise_x = xa;
      if (pvon && !von_a) begin vf_x = xa; vf_prev = px; end
      if (xa != px) begin
        if (xa == 0) begin
          wrapped = 1'b1; wrap_prev = px; wrap_y = ya;
          wrap_hs = hs_a; wrap_von = von_a;
        end else if (xa != px + 1) step_err++;
      end
      px = xa; phs = hs_a; pvon = von_a;
    end
    checks += 11;
    if (!wrapped) begin errors++; $display("FAIL line_wrap timeout got 0 want 1"); end
    if (step_err != 0) begin errors++; $display("FAIL x_step got %0d bad want 0", step_err); end
    if (vf_x != 640) begin errors++; $display("FAIL von_fall_x got %0d want 640", vf_x); end
    if (vf_prev != 639) begin errors++; $display("FAIL von_prev_x got %0d want 639", vf_prev); end
    if (fall_x != 656) begin errors++; $display("FAIL hs_fall_x got %0d want 656", fall_x); end
    if (rise_x != 752) begin errors++; $display("FAIL hs_rise_x got %0d want 752", rise_x); end
    if (low_cnt != 384) begin errors++; $display("FAIL hs_low_clks got %0d want 384", low_cnt); end
    if (wrap_prev != 799) begin errors++; $display("FAIL wrap_from got %0d want 799", wrap_prev); end
    if (wrap_y != 1) begin errors++; $display("FAIL wrap_y got %0d want 1", wrap_y); end
    if (wrap_hs != 1) begin errors++; $display("FAIL wrap_hs got %0d want 1", wrap_hs); end
    if (wrap_von != 1) begin errors++; $display("FAIL wrap_von got %0d want 1", wrap_von); end
  endtask

  task automatic test_reset_mid_line();
    int n, lows;
    n = 0;
    while (xa != 10'd700 && n < 3400) begin cyc(); n++; end
    checks += 2;
    if (xa != 10'd700) begin errors++; $display("FAIL seek700 got %0d want 700", xa); end
    if (hs_a !== 1'b0) begin errors++; $display("FAIL hs_at700 got %b want 0", hs_a); end
    rst_a = 1'b1;
    cyc();
    checks += 5;
    if (xa !== 10'd0) begin errors++; $display("FAIL mrst_x got %0d want 0", xa); end
    if (ya !== 10'd0) begin errors++; $display("FAIL mrst_y got %0d want 0", ya); end
    if (hs_a !== 1'b1) begin errors++; $display("FAIL mrst_hs got %b want 1", hs_a); end
    if (pt_a !== 1'b0) begin errors++; $display("FAIL mrst_pt got %b want 0", pt_a); end
    if (von_a !== 1'b1) begin errors++; $display("FAIL mrst_von got %b want 1", von_a); end
    rst_a = 1'b0;
    lows = 0;
    for (int i = 0; i < 2000; i++) begin
      cyc();
      if (hs_a !== 1'b1 || vs_a !== 1'b1) lows++;
    end
    checks += 3;
    if (lows != 0) begin errors++; $display("FAIL mrst_sync_low got %0d want 0", lows); end
    if (xa !== 10'd500) begin errors++; $display("FAIL mrst_x2000 got %0d want 500", xa); end
    if (ya !== 10'd0) begin errors++; $display("FAIL mrst_y2000 got %0d want 0", ya); end
  endtask

  task automatic test_vsync();
    int py;
    logic exp_vs, exp_von;
    rst_b = 1'b1;
    repeat (2) cyc();
    rst_b = 1'b0;
    py = 0;
    for (int i = 0; i < 1100 && py != 12; i++) begin
      cyc();
      if (yb != py) begin
        py = yb;
        exp_vs  = (py == 10 || py == 11) ? 1'b0 : 1'b1;
        exp_von = (py < 8) ? 1'b1 : 1'b0;
        checks += 2;
        if (vs_b !== exp_vs) begin
          errors++; $display("FAIL vs_y%0d got %b want %b", py, vs_b, exp_vs);
        end
        if (von_b !== exp_von) begin
          errors++; $display("FAIL von_y%0d got %b want %b", py, von_b, exp_von);
        end
      end
    end
    checks++;
    if (py != 12) begin errors++; $display("FAIL vs_reach12 got %0d want 12", py); end
  endtask

  task automatic test_frame_start();
    int n, px, py;
    n = 0; px = xb; py = yb;
    while (fs_b !== 1'b1 && n < 2200) begin
      px = xb; py = yb; cyc(); n++;
    end
    checks += 5;
    if (fs_b !== 1'b1) begin errors++; $display("FAIL fs_seen got %b want 1", fs_b); end
    if (xb !== 10'd0 || yb !== 10'd0) begin
      errors++; $display("FAIL fs_xy got %0d,%0d want 0,0", xb, yb);
    end
    if (px != 16 || py != 14) begin
      errors++; $display("FAIL fs_from got %0d,%0d want 16,14", px, py);
    end
    cyc();
    if (fs_b !== 1'b0) begin errors++; $display("FAIL fs_width got %b want 0", fs_b); end
    n = 1;
    while (fs_b !== 1'b1 && n < 2200) begin cyc(); n++; end
    if (n != 1020) begin errors++; $display("FAIL fs_period got %0d want 1020", n); end
  endtask

  task automatic test_reset_in_sync();
    int n, lows;
    n = 0;
    while (!(xb == 10'd13 && yb == 10'd10) && n < 1100) begin cyc(); n++; end
    checks += 2;
    if (hs_b !== 1'b0) begin errors++; $display("FAIL sync_hs_in got %b want 0", hs_b); end
    if (vs_b !== 1'b0) begin errors++; $display("FAIL sync_vs_in got %b want 0", vs_b); end
    rst_b = 1'b1;
    cyc();
    checks += 4;
    if (hs_b !== 1'b1) begin errors++; $display("FAIL srst_hs got %b want 1", hs_b); end
    if (vs_b !== 1'b1) begin errors++; $display("FAIL srst_vs got %b want 1", vs_b); end
    if (xb !== 10'd0 || yb !== 10'd0) begin
      errors++; $display("FAIL srst_xy got %0d,%0d want 0,0", xb, yb);
    end
    if (fs_b !== 1'b0) begin errors++; $display("FAIL srst_fs got %b want 0", fs_b); end
    rst_b = 1'b0;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (hs_b !== 1'b1 || vs_b !== 1'b1) lows++;
    end
    checks += 2;
    if (lows != 0) begin errors++; $display("FAIL srst_partial got %0d want 0", lows); end
    if (xb !== 10'd10) begin errors++; $display("FAIL srst_x40 got %0d want 10", xb); end
  endtask

  task automatic test_div1();
    int pt_low, hs_bad, vs_bad, first, second;
    logic exp_hs, exp_vs;
    rst_c = 1'b1;
    repeat (2) cyc();
    checks += 4;
    if (pt_c !== 1'b0) begin errors++; $display("FAIL d1_rst_pt got %b want 0", pt_c); end
    if (hs_c !== 1'b0) begin errors++; $display("FAIL d1_rst_hs got %b want 0", hs_c); end
    if (vs_c !== 1'b0) begin errors++; $display("FAIL d1_rst_vs got %b want 0", vs_c); end
    if (fs_c !== 1'b0) begin errors++; $display("FAIL d1_rst_fs got %b want 0", fs_c); end
    rst_c = 1'b0;
    pt_low = 0; hs_bad = 0; vs_bad = 0; first = -1; second = -1;
    for (int i = 0; i < 600; i++) begin
      cyc();
      exp_hs = (xc >= 10'd12 && xc <= 10'd14);
      exp_vs = (yc == 10'd10 || yc == 10'd11);
      if (pt_c !== 1'b1) pt_low++;
      if (hs_c !== exp_hs) hs_bad++;
      if (vs_c !== exp_vs) vs_bad++;
      if (fs_c === 1'b1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    checks += 5;
    if (pt_low != 0) begin errors++; $display("FAIL d1_pt_low got %0d want 0", pt_low); end
    if (hs_bad != 0) begin errors++; $display("FAIL d1_hs got %0d bad want 0", hs_bad); end
    if (vs_bad != 0) begin errors++; $display("FAIL d1_vs got %0d bad want 0", vs_bad); end
    if (first != 255) begin errors++; $display("FAIL d1_fs_first got %0d want 255", first); end
    if (second - first != 255) begin
      errors++; $display("FAIL d1_fs_period got %0d want 255", second - first);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_line();
    test_reset_mid_line();
    test_vsync();
    test_frame_start();
    test_reset_in_sync();
    test_div1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
